// File: rtl/btn_pkg.sv
// Shared event codes, FSM state encoding and timer sizing for the button event decoder.
package btn_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2,
    EV_REPEAT  = 2'd3
  } ev_code_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_REPEAT  = 2'd2
  } state_e;

  // The timer must hold the larger terminal count without wrapping.
  function automatic int timer_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/event_slot.sv
// One-entry valid/ready event holding register; a load into a full, unaccepted slot sets sticky overflow.
import btn_pkg::*;

module event_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] code_in,
  input  logic       ready,
  output logic       valid,
  output logic [1:0] code,
  output logic       overflow
);

  logic free;
  assign free = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      code     <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (load && free) begin
        valid <= 1'b1;
        code  <= code_in;
      end else if (load) begin
        overflow <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into handshaked PRESS/RELEASE/LONG/REPEAT events.
import btn_pkg::*;

module button_event_decoder #(
  parameter int LONG_COUNTS   = 50_000_000,
  parameter int REPEAT_COUNTS = 10_000_000,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_level,
  input  logic       repeat_en,
  output logic       event_valid,
  output logic [1:0] event_code,
  input  logic       event_ready,
  output logic       held,
  output logic       overflow
);

  localparam int            TW        = timer_w(LONG_COUNTS, REPEAT_COUNTS);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_COUNTS - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_COUNTS - 1);

  state_e        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          prev_level, act, rise, fall;
  logic          ev_load;
  ev_code_e      ev_code;

  assign act  = button_level ^ ACTIVE_LOW;
  assign rise = act && !prev_level;
  assign fall = !act && prev_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      prev_level <= 1'b0;
      held       <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      prev_level <= act;
      held       <= (state_n != S_IDLE);
    end
  end

  // Fall is tested before any threshold so a release always wins.
  always_comb begin
    state_n = state;
    timer_n = timer;
    ev_load = 1'b0;
    ev_code = EV_PRESS;
    unique case (state)
      S_IDLE: begin
        timer_n = '0;
        if (rise) begin
          ev_load = 1'b1;
          ev_code = EV_PRESS;
          state_n = S_PRESSED;
        end
      end
      S_PRESSED: begin
        if (fall) begin
          ev_load = 1'b1;
          ev_code = EV_RELEASE;
          state_n = S_IDLE;
          timer_n = '0;
        end else if (timer == LONG_LAST) begin
          ev_load = 1'b1;
          ev_code = EV_LONG;
          state_n = S_REPEAT;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_REPEAT: begin
        if (fall) begin
          ev_load = 1'b1;
          ev_code = EV_RELEASE;
          state_n = S_IDLE;
          timer_n = '0;
        end else if (!repeat_en) begin
          timer_n = '0;
        end else if (timer == REP_LAST) begin
          ev_load = 1'b1;
          ev_code = EV_REPEAT;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
  end

  event_slot u_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (ev_load),
    .code_in  (ev_code),
    .ready    (event_ready),
    .valid    (event_valid),
    .code     (event_code),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor checks each accepted one.
module tb_button_event_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       button_level;
  logic       repeat_en;
  logic       event_valid;
  logic [1:0] event_code;
  logic       event_ready;
  logic       held;
  logic       overflow;

  typedef struct {
    int code;
    int cyc;   // -1: acceptance time not checked
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  button_event_decoder #(
    .LONG_COUNTS   (8),
    .REPEAT_COUNTS (4),
    .ACTIVE_LOW    (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button_level (button_level),
    .repeat_en    (repeat_en),
    .event_valid  (event_valid),
    .event_code   (event_code),
    .event_ready  (event_ready),
    .held         (held),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int code, input int c);
    exp_t e;
    e.code = code;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // A transfer happens at the next posedge whenever valid&ready is seen here.
  always @(negedge clk) begin
    if (event_valid && event_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", int'(event_code), -1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_code", int'(event_code), e.code);
        if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int t0;
    rst          = 1'b1;
    button_level = 1'b0;
    repeat_en    = 1'b1;
    event_ready  = 1'b1;
    step(2);
    chk("rst_valid", event_valid, 0);
    chk("rst_code", event_code, 0);
    chk("rst_held", held, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    step(2);

    // short press
    button_level = 1'b1; t0 = cyc + 1;
    push(0, t0); push(1, t0 + 3);
    step(1);
    chk("short_held_t0", held, 1);
    step(2);
    chk("short_held_t2", held, 1);
    button_level = 1'b0;
    step(1);
    chk("short_held_t3", held, 0);
    step(3);

    // long hold with repeats; release coincides with a REPEAT threshold
    button_level = 1'b1; t0 = cyc + 1;
    push(0, t0); push(2, t0 + 8); push(3, t0 + 12); push(3, t0 + 16); push(1, t0 + 20);
    step(20);
    chk("long_held", held, 1);
    button_level = 1'b0;
    step(1);
    chk("long_held_rel", held, 0);
    chk("long_ovf", overflow, 0);
    step(3);

    // repeat disabled
    repeat_en = 1'b0;
    button_level = 1'b1; t0 = cyc + 1;
    push(0, t0); push(2, t0 + 8); push(1, t0 + 20);
    step(20);
    button_level = 1'b0;
    step(4);
    repeat_en = 1'b1;

    // backpressure: RELEASE dropped behind a pending PRESS
    event_ready = 1'b0;
    button_level = 1'b1;
    push(0, -1);
    step(2);
    button_level = 1'b0;
    step(2);
    chk("bp_valid", event_valid, 1);
    chk("bp_code", event_code, 0);
    chk("bp_ovf", overflow, 1);
    event_ready = 1'b1;
    step(1);
    chk("bp_valid_after", event_valid, 0);
    step(2);
    chk("bp_valid_idle", event_valid, 0);
    chk("bp_ovf_sticky", overflow, 1);

    // async reset in REPEAT, level held through it
    button_level = 1'b1; t0 = cyc + 1;
    push(0, t0); push(2, t0 + 8);
    step(10);
    chk("pre_rst_held", held, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", event_valid, 0);
    chk("mid_rst_code", event_code, 0);
    chk("mid_rst_held", held, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0; t0 = cyc + 1;
    push(0, t0); push(2, t0 + 8); push(1, t0 + 10);
    step(10);
    button_level = 1'b0;
    step(4);

    // acceptance on the same edge LONG is loaded
    event_ready = 1'b0;
    button_level = 1'b1; t0 = cyc + 1;
    push(0, -1); push(2, t0 + 8);
    step(8);
    event_ready = 1'b1;
    step(1);
    chk("same_valid", event_valid, 1);
    chk("same_code", event_code, 2);
    chk("same_ovf", overflow, 0);
    button_level = 1'b0;
    push(1, t0 + 9);
    step(4);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumer of a debounced button level. It converts the clean level into discrete, handshaked button events: PRESS, RELEASE, LONG and REPEAT.
- Sits between the per-button debounce stage and the UI/control logic, so downstream FSMs never poll raw levels or time holds themselves.
- Single clock domain. Input must already be synchronised and debounced.

Parameters:
- LONG_COUNTS, 50_000_000, cycles the button must stay active before LONG is emitted (1 s at 50 MHz); legal values are 2 or more.
- REPEAT_COUNTS, 10_000_000, cycles between successive REPEAT events after LONG (200 ms at 50 MHz); legal values are 1 or more.
- ACTIVE_LOW, 0, set to 1 when button_level is low while pressed (on-board KEYs).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-high.
- button_level  in  1  debounced, synchronised button level.
- repeat_en  in  1  1 = emit REPEAT events after LONG; sampled every cycle.
- event_valid  out  1  an event is presented.
- event_code  out  2  0 = PRESS, 1 = RELEASE, 2 = LONG, 3 = REPEAT.
- event_ready  in  1  consumer accepts the event when event_valid and event_ready are both high at a clk edge.
- held  out  1  registered; 1 while the decoder is in any pressed state.
- overflow  out  1  sticky; an event was dropped. Cleared only by rst.

Behaviour:
- Reset values:
  - Asynchronous rst forces state IDLE, timer 0, prev_level 0, event_valid 0, event_code 0, held 0, overflow 0.
  - prev_level resets to 0, so a button held through reset yields PRESS on the first edge after rst deasserts.
- Level conditioning:
  - The active level is button_level XOR ACTIVE_LOW.
  - prev_level registers the active level every edge.
  - Rise = active and not prev_level. Fall = not active and prev_level.
- Timer width is clog2(max(LONG_COUNTS, REPEAT_COUNTS) + 1). The timer never wraps; it is cleared on every state change.
- State IDLE:
  - On Rise, emit PRESS, clear the timer and go to PRESSED.
  - Otherwise remain in IDLE.
- State PRESSED:
  - On Fall, emit RELEASE and go to IDLE.
  - If the timer reaches LONG_COUNTS-1 while still active, emit LONG, clear the timer and go to REPEAT.
  - Otherwise increment the timer.
- State REPEAT:
  - On Fall, emit RELEASE and go to IDLE.
  - If repeat_en is 1 and the timer reaches REPEAT_COUNTS-1, emit REPEAT and clear the timer.
  - If repeat_en is 0, hold the timer at 0 and emit nothing.
- Resulting timing: with the rise sampled at edge t0, PRESS is loaded at t0, LONG at t0+LONG_COUNTS, and REPEAT at t0+LONG_COUNTS+k*REPEAT_COUNTS for k = 1, 2, …
- held is 1 in PRESSED and REPEAT, and 0 in IDLE. It is registered together with the state.
- Latency: an event is loaded into the output slot on the same edge that samples its cause, so event_valid is visible one cycle after the causing input change.
- Output slot (one entry):
  - While event_valid=1 and event_ready=0, event_code holds stable.
  - If a new event and an acceptance occur on the same edge, the new event is loaded and event_valid stays 1.
  - If a new event arrives while the slot is full and not being accepted, the new event is dropped and overflow is set to 1. The FSM still advances normally.
  - If there is an acceptance and no new event, event_valid goes to 0.
- Simultaneous Rise and Fall are impossible (single level input).
- A release on the same edge as a LONG or REPEAT threshold: Fall wins, so RELEASE is emitted and the LONG/REPEAT is not.

Decomposition:
- Shared package btn_pkg holds:
  - the event code constants EV_PRESS, EV_RELEASE, EV_LONG, EV_REPEAT;
  - the state encoding S_IDLE, S_PRESSED, S_REPEAT.
- One sub-module, event_slot: the one-entry valid/ready holding register with overflow detection (inputs load, code_in, ready; outputs valid, code, overflow).

Test Plan (all scenarios use LONG_COUNTS=8, REPEAT_COUNTS=4, ACTIVE_LOW=0, event_ready=1 unless stated):
- Short press: level high for edges t0..t0+2, low from t0+3 -> PRESS valid after t0, RELEASE after t0+3, no LONG, held=1 for exactly 3 cycles.
- Long hold, repeat_en=1: level high for t0..t0+19 -> PRESS after t0, LONG after t0+8, REPEAT after t0+12 and t0+16, RELEASE after t0+20, overflow=0.
- repeat_en=0: hold for 20 cycles -> PRESS, LONG after t0+8, then only RELEASE after t0+20; no REPEAT.
- Backpressure: event_ready=0, press at t0, release at t0+2 -> code=PRESS stable, RELEASE dropped, overflow=1; raise ready -> exactly one transfer with code 0, then event_valid=0, and overflow stays 1.
- Same-edge accept: ready pulsed at exactly the LONG edge while PRESS is pending -> PRESS transferred, LONG loaded, valid stays 1, overflow=0.
- Reset mid-hold: assert rst asynchronously in REPEAT -> all outputs 0 immediately; deassert with level still high -> PRESS after the first edge, LONG 8 cycles later.
